// File: rtl/button_pkg.sv
// Shared state encoding and timing defaults for the button conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

  localparam int unsigned DEFAULT_NUM_BUTTONS     = 3;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 12000;
  localparam int unsigned DEFAULT_LONG_CYCLES     = 12000000;

  // Counter width for a terminal count n; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchronizer, debounce FSM, hold counter, registered pulses.
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic button_i,
  output logic pressed_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HW = cnt_width(LONG_CYCLES);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] LMAX = HW'(LONG_CYCLES - 1);

  btn_state_t    state;
  logic          meta;
  logic          sync;
  logic [DW-1:0] dcnt;
  logic [HW-1:0] hcnt;
  logic          long_done;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      meta      <= 1'b1;
      sync      <= 1'b1;
      state     <= RELEASED;
      dcnt      <= '0;
      hcnt      <= '0;
      long_done <= 1'b0;
      pressed_o <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
      long_o    <= 1'b0;
    end else begin
      meta      <= button_i;
      sync      <= meta;
      press_o   <= 1'b0;
      release_o <= 1'b0;
      long_o    <= 1'b0;

      // Hold time keeps accruing through RELEASE_WAIT so a bounce back to
      // PRESSED does not lose it; the long event itself only fires in PRESSED.
      if (state == PRESSED || state == RELEASE_WAIT) begin
        if (hcnt != '1) hcnt <= hcnt + 1'b1;
      end
      if (state == PRESSED && !long_done && hcnt >= LMAX) begin
        long_o    <= 1'b1;
        long_done <= 1'b1;
      end

      case (state)
        RELEASED: begin
          if (!sync) begin
            state <= PRESS_WAIT;
            dcnt  <= '0;
          end
        end
        PRESS_WAIT: begin
          if (sync) begin
            state <= RELEASED;
          end else if (dcnt == DMAX) begin
            state     <= PRESSED;
            press_o   <= 1'b1;
            pressed_o <= 1'b1;
            hcnt      <= '0;
            long_done <= 1'b0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        PRESSED: begin
          if (sync) begin
            state <= RELEASE_WAIT;
            dcnt  <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (!sync) begin
            state <= PRESSED;
          end else if (dcnt == DMAX) begin
            state     <= RELEASED;
            release_o <= 1'b1;
            pressed_o <= 1'b0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: state <= RELEASED;
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Debounces NUM_BUTTONS active-low buttons and reports press/release/long-press events.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS     = DEFAULT_NUM_BUTTONS,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_ni,
  input  logic [NUM_BUTTONS-1:0] button_i,
  output logic [NUM_BUTTONS-1:0] pressed_o,
  output logic [NUM_BUTTONS-1:0] press_o,
  output logic [NUM_BUTTONS-1:0] release_o,
  output logic [NUM_BUTTONS-1:0] long_o
);

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_chan (
      .clk      (clk),
      .rst_ni   (rst_ni),
      .button_i (button_i[g]),
      .pressed_o(pressed_o[g]),
      .press_o  (press_o[g]),
      .release_o(release_o[g]),
      .long_o   (long_o[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [2:0] button_i;
  logic [2:0] pressed_o, press_o, release_o, long_o;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned fails  = 0;
  logic [2:0]  seen;

  button_conditioner #(
    .NUM_BUTTONS    (3),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20)
  ) dut (
    .clk      (clk),
    .rst_ni   (rst_ni),
    .button_i (button_i),
    .pressed_o(pressed_o),
    .press_o  (press_o),
    .release_o(release_o),
    .long_o   (long_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100us;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    rst_ni   = 1'b0;
    button_i = 3'b111;
    step(2);
    chk("rst_pressed", pressed_o, 3'b000);
    chk("rst_press",   press_o,   3'b000);
    chk("rst_release", release_o, 3'b000);
    chk("rst_long",    long_o,    3'b000);
    rst_ni = 1'b1;
    step(3);

    // Clean press on bit 0, held 10 cycles
    button_i = 3'b110;
    step(6);
    chk("p0_early", press_o, 3'b000);
    step(1);
    chk("p0_press",   press_o,   3'b001);
    chk("p0_pressed", pressed_o, 3'b001);
    step(1);
    chk("p0_onecyc", press_o, 3'b000);
    step(2);
    button_i = 3'b111;
    step(6);
    chk("r0_early", release_o, 3'b000);
    step(1);
    chk("r0_release", release_o, 3'b001);
    chk("r0_pressed", pressed_o, 3'b000);
    step(2);

    // Short glitch on bit 1 is rejected
    button_i = 3'b101;
    step(2);
    button_i = 3'b111;
    seen = '0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      seen = seen | press_o | release_o | long_o | pressed_o;
    end
    chk("g1_nopulse", seen, 3'b000);

    // All buttons together
    button_i = 3'b000;
    step(6);
    chk("all_early", press_o, 3'b000);
    step(1);
    chk("all_press",   press_o,   3'b111);
    chk("all_pressed", pressed_o, 3'b111);
    step(3);
    button_i = 3'b111;
    step(6);
    chk("all_rel_early", release_o, 3'b000);
    step(1);
    chk("all_release", release_o, 3'b111);
    chk("all_released", pressed_o, 3'b000);
    step(2);

    // Long press on bit 2, held 30 cycles
    button_i = 3'b011;
    step(7);
    chk("l2_pressed", pressed_o, 3'b100);
    step(19);
    chk("l2_long_early", long_o, 3'b000);
    step(1);
    chk("l2_long", long_o, 3'b100);
    seen = '0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      seen = seen | long_o;
    end
    button_i = 3'b111;
    for (int i = 0; i < 6; i++) begin
      step(1);
      seen = seen | long_o;
    end
    chk("l2_norepeat", seen, 3'b000);
    step(1);
    chk("l2_release", release_o, 3'b100);
    step(2);

    // One-cycle high glitch while bit 0 is pressed
    button_i = 3'b110;
    step(7);
    chk("h0_pressed", pressed_o, 3'b001);
    step(2);
    button_i = 3'b111;
    step(1);
    button_i = 3'b110;
    seen = '0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      seen = seen | release_o | long_o;
    end
    chk("h0_norelease", seen, 3'b000);
    chk("h0_still",     pressed_o, 3'b001);
    button_i = 3'b111;
    step(7);
    chk("h0_release", release_o, 3'b001);
    step(2);

    // Reset during PRESS_WAIT with button held
    button_i = 3'b110;
    step(4);
    rst_ni = 1'b0;
    #1;
    seen = press_o | release_o | long_o | pressed_o;
    step(2);
    seen = seen | press_o | release_o | long_o | pressed_o;
    chk("rw_outputs", seen, 3'b000);
    rst_ni = 1'b1;
    step(6);
    chk("rw_early", press_o, 3'b000);
    step(1);
    chk("rw_press",   press_o,   3'b001);
    chk("rw_pressed", pressed_o, 3'b001);
    button_i = 3'b111;
    step(10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter NUM_BUTTONS, default 3, number of independent button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 12000 (1 ms at 12 MHz), consecutive stable cycles required to accept a level change.
REQ-003 SHALL have parameter LONG_CYCLES, default 12000000 (1 s at 12 MHz), cycles held in PRESSED before a long-press event.
REQ-004 SHALL provide clk  input  1  system clock, 12 MHz, rising-edge.
REQ-005 SHALL provide rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL provide button_i  input  NUM_BUTTONS  raw asynchronous buttons, active-low (0 = pressed).
REQ-007 SHALL provide pressed_o  output  NUM_BUTTONS  debounced level, active-high (1 = pressed).
REQ-008 SHALL provide press_o  output  NUM_BUTTONS  one-cycle pulse on accepted press.
REQ-009 SHALL provide release_o  output  NUM_BUTTONS  one-cycle pulse on accepted release.
REQ-010 SHALL provide long_o  output  NUM_BUTTONS  one-cycle pulse when a press reaches LONG_CYCLES.

Function
REQ-011 SHALL pass each button_i bit through a 2-flop synchronizer; all further logic uses only the synchronized bit.
REQ-012 SHALL run one independent FSM per channel, states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-013 RELEASED: sync bit 0 -> PRESS_WAIT with counter cleared; otherwise stay.
REQ-014 PRESS_WAIT: sync bit 1 -> RELEASED (glitch rejected, no pulse); counter reaching DEBOUNCE_CYCLES-1 with bit 0 -> PRESSED.
REQ-015 PRESSED: sync bit 1 -> RELEASE_WAIT with counter cleared; otherwise the hold counter increments and saturates.
REQ-016 RELEASE_WAIT: sync bit 0 -> PRESSED (glitch rejected, hold counter preserved, no pulse); counter reaching DEBOUNCE_CYCLES-1 with bit 1 -> RELEASED.
REQ-017 press_o SHALL pulse exactly one cycle, registered, in the cycle after the PRESS_WAIT->PRESSED transition; pressed_o rises in the same cycle.
REQ-018 release_o SHALL pulse exactly one cycle in the cycle after the RELEASE_WAIT->RELEASED transition; pressed_o falls in the same cycle.
REQ-019 Total latency from a clean button_i edge to press_o/release_o SHALL be 2 + DEBOUNCE_CYCLES + 1 clocks.
REQ-020 long_o SHALL pulse once per press when the hold counter equals LONG_CYCLES-1; it SHALL NOT repeat while held, and SHALL NOT fire if release is accepted first.
REQ-021 Time spent in RELEASE_WAIT that ends in a bounce back to PRESSED SHALL count toward LONG_CYCLES.
REQ-022 Counter widths SHALL be $clog2 of the respective parameter, with no wrap-around; the hold counter saturates.
REQ-023 Channels SHALL be fully independent; simultaneous events on several channels SHALL all produce pulses in the same cycle.
REQ-024 DEBOUNCE_CYCLES=1 SHALL be legal and give an accept after one stable synchronized cycle.

Reset
REQ-025 On rst_ni low, synchronizer flops SHALL preset to 1 (unpressed), FSMs go to RELEASED, and counters clear.
REQ-026 During reset pressed_o, press_o, release_o and long_o SHALL all be 0.
REQ-027 A button held through reset deassertion SHALL be accepted as a new press after the normal latency.
REQ-028 Reset asserted mid-debounce or mid-hold SHALL discard in-progress state without emitting any pulse.

Structure
REQ-029 The FSM state enum and default timing constants SHALL reside in a shared package button_pkg.
REQ-030 Per-channel logic (synchronizer, FSM, counters) SHALL be a sub-module button_channel, instantiated NUM_BUTTONS times by a generate loop.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-031 Clean press on bit 0 held for 10 cycles -> press_o[0] pulses 7 cycles after the edge, pressed_o=001, no other pulses.
REQ-032 Bit 1 low for 2 cycles then high -> no pulses, pressed_o stays 000.
REQ-033 All buttons 3'b111->3'b000 simultaneously -> press_o=111 in one cycle; release to 111 -> release_o=111 seven cycles later.
REQ-034 Bit 2 held for 30 cycles -> exactly one long_o[2] pulse, 20 cycles after pressed_o[2] rises.
REQ-035 1-cycle high glitch while bit 0 is pressed -> no release_o, pressed_o[0] stays 1.
REQ-036 rst_ni pulsed low while bit 0 is in PRESS_WAIT -> all outputs 0; with the button still held, press_o[0] pulses 7 cycles after reset release.
